// File: rtl/round_sequencer_if.sv
// Handshake/bus bundle for round_sequencer.
//   slave  : the sequencer side (player inputs in, display/score outputs out)
//   master : the player/display side driving start and player moves
//   start        1-cycle pulse, begins a game
//   player_valid 1-cycle pulse, player_code is valid
//   player_code  player move 1..4 (others never match)
//   disp_code    move shown to the display, 0 = blank
//   disp_valid   high while a move is being shown
//   listening    high while waiting for player moves
//   round_pass   1-cycle pulse on a completed round
//   game_over    high once the game has ended
//   win          high in game over only after a full-length round
//   level/score/lives  game status
interface round_sequencer_if;
   logic       start;
   logic       player_valid;
   logic [2:0] player_code;
   logic [2:0] disp_code;
   logic       disp_valid;
   logic       listening;
   logic       round_pass;
   logic       game_over;
   logic       win;
   logic [3:0] level;
   logic [7:0] score;
   logic [1:0] lives;

   modport slave (
      input  start, player_valid, player_code,
      output disp_code, disp_valid, listening, round_pass, game_over, win,
             level, score, lives
   );

   modport master (
      output start, player_valid, player_code,
      input  disp_code, disp_valid, listening, round_pass, game_over, win,
             level, score, lives
   );
endinterface

// File: rtl/round_sequencer.sv
// Simon-style game-round controller. Grows a random move sequence one entry
// per round, plays it to the display one tick per step, then checks the
// player's moves and keeps level, score and lives.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   rs    : round_sequencer_if.slave (start/player inputs, display/status outputs)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, all outputs 0, waits for start
// S_GEN    | appends one new move at seq[level-1]
// S_SHOW   | shows seq[idx] for one tick
// S_GAP    | blank display for one tick, then next move or listen
// S_LISTEN | compares player moves against the sequence, timeout running
// S_PASS   | round complete: score += level, next level or win
// S_FAIL   | mismatch or timeout: lose a life, replay or game over
// S_OVER   | game ended, status held until the next start
module round_sequencer #(
   parameter int MAX_LEN       = 8,
   parameter int TICK_DIV      = 25000000,
   parameter int TIMEOUT_TICKS = 10,
   parameter int START_LIVES   = 3
) (
   input  logic             clock,
   input  logic             reset,
   round_sequencer_if.slave rs
);

   localparam int IDXW = $clog2(MAX_LEN);
   localparam int TW   = $clog2(TICK_DIV);
   localparam int TMW  = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [TW-1:0]  TICK_LOAD  = TW'(TICK_DIV - 1);
   localparam logic [TMW-1:0] TMO_LOAD   = TMW'(TIMEOUT_TICKS);
   localparam logic [3:0]     LEN_MAX    = 4'(MAX_LEN);
   localparam logic [1:0]     LIVES_INIT = 2'(START_LIVES);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_SHOW, S_GAP, S_LISTEN, S_PASS, S_FAIL, S_OVER
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      level_q, level_d;
   logic [7:0]      score_q, score_d;
   logic [1:0]      lives_q, lives_d;
   logic [3:0]      idx_q, idx_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [TMW-1:0]  timer_q, timer_d;
   logic            win_q, win_d;
   logic [15:0]     lfsr_q;
   logic [2:0]      seq_q [MAX_LEN];

   logic            tick;
   logic [2:0]      move_new;
   logic [2:0]      seq_rd;
   logic [IDXW-1:0] wr_idx;
   logic [8:0]      score_sum;

   assign tick      = (tick_q == '0);
   assign move_new  = {1'b0, lfsr_q[1:0]} + 3'd1;
   assign seq_rd    = seq_q[idx_q[IDXW-1:0]];
   assign wr_idx    = IDXW'(level_q - 4'd1);
   assign score_sum = {1'b0, score_q} + {5'd0, level_q};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         level_q <= '0;
         score_q <= '0;
         lives_q <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
         timer_q <= '0;
         win_q   <= 1'b0;
         lfsr_q  <= 16'hACE1;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         score_q <= score_d;
         lives_q <= lives_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         timer_q <= timer_d;
         win_q   <= win_d;
         lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   // Sequence memory has no reset; entries are always written before read.
   always_ff @(posedge clock) begin
      if (state_q == S_GEN) seq_q[wr_idx] <= move_new;
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      score_d = score_q;
      lives_d = lives_q;
      idx_d   = idx_q;
      tick_d  = tick_q;
      timer_d = timer_q;
      win_d   = win_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (rs.start) begin
               state_d = S_GEN;
               level_d = 4'd1;
               score_d = '0;
               lives_d = LIVES_INIT;
               win_d   = 1'b0;
            end
         end
         S_GEN: begin
            state_d = S_SHOW;
            idx_d   = '0;
            tick_d  = TICK_LOAD;
         end
         S_SHOW: begin
            tick_d = tick_q - 1'b1;
            if (tick) begin
               state_d = S_GAP;
               tick_d  = TICK_LOAD;
            end
         end
         S_GAP: begin
            tick_d = tick_q - 1'b1;
            if (tick) begin
               tick_d = TICK_LOAD;
               if (idx_q + 4'd1 == level_q) begin
                  state_d = S_LISTEN;
                  idx_d   = '0;
                  timer_d = TMO_LOAD;
               end else begin
                  state_d = S_SHOW;
                  idx_d   = idx_q + 4'd1;
               end
            end
         end
         S_LISTEN: begin
            tick_d = tick_q - 1'b1;
            // A move in the same cycle as the timeout wins over the timeout.
            if (rs.player_valid) begin
               if (rs.player_code != seq_rd) begin
                  state_d = S_FAIL;
               end else if (idx_q == level_q - 4'd1) begin
                  state_d = S_PASS;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  tick_d  = TICK_LOAD;
                  timer_d = TMO_LOAD;
               end
            end else if (tick) begin
               tick_d = TICK_LOAD;
               if (timer_q <= TMW'(1)) state_d = S_FAIL;
               else                    timer_d = timer_q - 1'b1;
            end
         end
         S_PASS: begin
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
            if (level_q == LEN_MAX) begin
               state_d = S_OVER;
               win_d   = 1'b1;
            end else begin
               state_d = S_GEN;
               level_d = level_q + 4'd1;
            end
         end
         S_FAIL: begin
            lives_d = lives_q - 2'd1;
            if (lives_q <= 2'd1) begin
               state_d = S_OVER;
               win_d   = 1'b0;
            end else begin
               state_d = S_SHOW;
               idx_d   = '0;
               tick_d  = TICK_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rs.disp_code  = (state_q == S_SHOW) ? seq_rd : 3'd0;
   assign rs.disp_valid = (state_q == S_SHOW);
   assign rs.listening  = (state_q == S_LISTEN);
   assign rs.round_pass = (state_q == S_PASS);
   assign rs.game_over  = (state_q == S_OVER);
   assign rs.win        = (state_q == S_OVER) && win_q;
   assign rs.level      = level_q;
   assign rs.score      = score_q;
   assign rs.lives      = lives_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Randomized game-level bench for round_sequencer with a transaction-style
// reference model: expected sequence queue, level/score/lives, and phase
// lengths derived from TICK_DIV and TIMEOUT_TICKS.
module tb_round_sequencer;
   localparam int MAX_LEN       = 3;
   localparam int TICK_DIV      = 4;
   localparam int TIMEOUT_TICKS = 3;
   localparam int START_LIVES   = 2;
   localparam int LISTEN_CYC    = TICK_DIV * TIMEOUT_TICKS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   round_sequencer_if rs_if();

   round_sequencer #(
      .MAX_LEN       (MAX_LEN),
      .TICK_DIV      (TICK_DIV),
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .START_LIVES   (START_LIVES)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .rs    (rs_if.slave)
   );

   always #5 clk = ~clk;

   // Free-running random source as described: shift left each clock.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   int n_checks = 0;
   int n_err    = 0;
   int m_level, m_score, m_lives, m_idx;
   int exp_seq[$];
   int script[$];
   int reset_at_level = 0;
   bit aborted;
   bit done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_disp_code"},  32'(rs_if.disp_code),  0);
      chk({tag, "_disp_valid"}, 32'(rs_if.disp_valid), 0);
      chk({tag, "_listening"},  32'(rs_if.listening),  0);
      chk({tag, "_round_pass"}, 32'(rs_if.round_pass), 0);
      chk({tag, "_game_over"},  32'(rs_if.game_over),  0);
      chk({tag, "_win"},        32'(rs_if.win),        0);
      chk({tag, "_level"},      32'(rs_if.level),      0);
      chk({tag, "_score"},      32'(rs_if.score),      0);
      chk({tag, "_lives"},      32'(rs_if.lives),      0);
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_level"}, 32'(rs_if.level), m_level);
      chk({tag, "_score"}, 32'(rs_if.score), m_score);
      chk({tag, "_lives"}, 32'(rs_if.lives), m_lives);
   endtask

   // Called mid-SHOW: asynchronous reset, start held during reset, release.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      rs_if.start = 1'b1;
      step();
      step();
      rs_if.start = 1'b0;
      chk_all_zero("rst_vs_start");
      @(negedge clk) rst_n = 1'b1;
      step();
      chk_all_zero("post_rst_idle");
   endtask

   // Starts in the cycle before SHOW (GEN or FAIL); ends in LISTEN cycle 1.
   task automatic show_phase();
      for (int i = 0; i < m_level; i++) begin
         for (int t = 0; t < TICK_DIV; t++) begin
            step();
            rs_if.player_valid = 1'b0;
            rs_if.start        = 1'b0;
            if (reset_at_level == m_level && i == 0 && t == 2) begin
               apply_reset();
               aborted = 1'b1;
               return;
            end
            chk("show_valid", 32'(rs_if.disp_valid), 1);
            chk("show_code",  32'(rs_if.disp_code),  exp_seq[i]);
            chk("show_listen", 32'(rs_if.listening), 0);
            if ($urandom_range(0, 5) == 0) begin
               rs_if.player_valid = 1'b1;
               rs_if.player_code  = 3'($urandom_range(0, 7));
            end
         end
         for (int t = 0; t < TICK_DIV; t++) begin
            step();
            rs_if.player_valid = 1'b0;
            rs_if.start        = 1'b0;
            chk("gap_valid", 32'(rs_if.disp_valid), 0);
            chk("gap_code",  32'(rs_if.disp_code),  0);
            if ($urandom_range(0, 5) == 0) rs_if.start = 1'b1;
         end
      end
      step();
      rs_if.player_valid = 1'b0;
      rs_if.start        = 1'b0;
      chk("listen_entry", 32'(rs_if.listening), 1);
      chk_status("listen");
      m_idx = 0;
   endtask

   task automatic push_move();
      exp_seq.push_back(int'(m_lfsr[1:0]) + 1);
   endtask

   task automatic do_start();
      rs_if.start = 1'b1;
      step();
      rs_if.start = 1'b0;
      m_level = 1;
      m_score = 0;
      m_lives = START_LIVES;
      exp_seq.delete();
      chk("gen_listen", 32'(rs_if.listening),  0);
      chk("gen_valid",  32'(rs_if.disp_valid), 0);
      chk("gen_over",   32'(rs_if.game_over),  0);
      chk("gen_win",    32'(rs_if.win),        0);
      chk_status("gen");
      push_move();
      show_phase();
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 7) == 0) rs_if.start = 1'b1;
         step();
         rs_if.start = 1'b0;
         chk("listen_hold", 32'(rs_if.listening), 1);
      end
   endtask

   task automatic hold_over(input int exp_win);
      for (int k = 0; k < 2; k++) begin
         rs_if.player_valid = 1'b1;
         rs_if.player_code  = 3'($urandom_range(1, 4));
         step();
         rs_if.player_valid = 1'b0;
         chk("over_hold", 32'(rs_if.game_over), 1);
         chk("over_win",  32'(rs_if.win), exp_win);
         chk_status("over_hold");
      end
   endtask

   task automatic on_pass();
      chk("pass_pulse",  32'(rs_if.round_pass), 1);
      chk("pass_listen", 32'(rs_if.listening),  0);
      m_score = (m_score + m_level > 255) ? 255 : m_score + m_level;
      step();
      chk("pass_once", 32'(rs_if.round_pass), 0);
      if (m_level == MAX_LEN) begin
         chk("win_over", 32'(rs_if.game_over), 1);
         chk("win_flag", 32'(rs_if.win), 1);
         chk_status("win");
         hold_over(1);
         done = 1'b1;
      end else begin
         m_level++;
         chk("gen2_valid", 32'(rs_if.disp_valid), 0);
         chk_status("gen2");
         push_move();
         show_phase();
         if (aborted) done = 1'b1;
      end
   endtask

   task automatic on_fail();
      chk("fail_listen", 32'(rs_if.listening),  0);
      chk("fail_pass",   32'(rs_if.round_pass), 0);
      chk("fail_over",   32'(rs_if.game_over),  0);
      m_lives--;
      if (m_lives == 0) begin
         step();
         chk("lose_over", 32'(rs_if.game_over), 1);
         chk("lose_win",  32'(rs_if.win), 0);
         chk_status("lose");
         hold_over(0);
         done = 1'b1;
      end else begin
         show_phase();
         if (aborted) done = 1'b1;
      end
   endtask

   // act: 0 correct, 1 wrong code, 2 timeout, 3 correct on timeout cycle, 4 code 0
   task automatic play_game();
      int act, d, code, guard, r;
      aborted = 1'b0;
      done    = 1'b0;
      do_start();
      if (aborted) return;
      guard = 0;
      while (!done && guard < 100) begin
         guard++;
         if (script.size() > 0) begin
            act = script.pop_front();
         end else begin
            r   = int'($urandom_range(0, 19));
            act = (r < 14) ? 0 : (r < 17) ? 1 : 2;
         end
         case (act)
            0, 3: begin
               d = (act == 3) ? LISTEN_CYC : int'($urandom_range(1, LISTEN_CYC));
               idle_cycles(d - 1);
               rs_if.player_valid = 1'b1;
               rs_if.player_code  = 3'(exp_seq[m_idx]);
               step();
               rs_if.player_valid = 1'b0;
               if (m_idx == m_level - 1) begin
                  on_pass();
               end else begin
                  m_idx++;
                  chk("next_listen", 32'(rs_if.listening),  1);
                  chk("next_nopass", 32'(rs_if.round_pass), 0);
               end
            end
            1, 4: begin
               d = int'($urandom_range(1, LISTEN_CYC));
               idle_cycles(d - 1);
               if (act == 4) code = 0;
               else do code = int'($urandom_range(0, 7)); while (code == exp_seq[m_idx]);
               rs_if.player_valid = 1'b1;
               rs_if.player_code  = 3'(code);
               step();
               rs_if.player_valid = 1'b0;
               on_fail();
            end
            default: begin
               idle_cycles(LISTEN_CYC - 1);
               step();
               on_fail();
            end
         endcase
      end
      if (!done) chk("game_bounded", 0, 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rs_if.start        = 1'b0;
      rs_if.player_valid = 1'b0;
      rs_if.player_code  = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      step();
      chk_all_zero("idle");

      // All replies correct: scores 1, 3, 6 and a win at level 3.
      repeat (6) script.push_back(0);
      play_game();
      chk("A_score", 32'(rs_if.score), 6);
      chk("A_level", 32'(rs_if.level), 3);
      chk("A_win",   32'(rs_if.win),   1);

      // Two wrong codes in round 1.
      script.push_back(1);
      script.push_back(1);
      play_game();
      chk("B_lives", 32'(rs_if.lives), 0);
      chk("B_level", 32'(rs_if.level), 1);
      chk("B_win",   32'(rs_if.win),   0);

      // Timeout, then a correct move on the exact timeout cycle, then code 0.
      script.push_back(2);
      script.push_back(3);
      script.push_back(4);
      play_game();
      chk("C_score", 32'(rs_if.score), 1);
      chk("C_level", 32'(rs_if.level), 2);
      chk("C_lives", 32'(rs_if.lives), 0);

      // Reset in the middle of SHOW in round 2, then a fresh game.
      reset_at_level = 2;
      script.push_back(0);
      play_game();
      reset_at_level = 0;
      script.delete();
      play_game();

      repeat (15) play_game();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
